credit_tracker: RTL and testbench
=================================

# credit_tracker

Parametrised per-output, per-VC credit tracker for the NoC router. It counts downstream buffer space per output port and VC, and holds returned credits in a per-port timestamped delay queue. A credit is released into its counter only after the programmed credit delay. It replaces the fixed-size, resetless credit logic in the router with:

- configurable port, VC, depth and delay widths;
- asynchronous reset;
- same-cycle consume/return arithmetic;
- sticky error reporting.

## Interface
Parameters:
- NUM_PORTS, 5, number of output ports tracked
- NUM_VCS, 4, virtual channels per port
- BUF_DEPTH, 4, downstream buffer slots per VC; reset and maximum credit count
- CQ_DEPTH, 8, credit-queue entries per port; power of two, ≥2
- DELAY_W, 12, width of credit delay
- TS_W, 16, cycle-counter/timestamp width; must be > DELAY_W

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  load cfg_delay
- cfg_delay  in  DELAY_W  credit delay in cycles
- cr_in_valid  in  NUM_PORTS  credit returned from downstream, one bit per port
- cr_in_vc  in  NUM_PORTS*VC_W  VC of each returned credit; VC_W = max(1,$clog2(NUM_VCS))
- consume_valid  in  NUM_PORTS  flit sent on port, one bit per port
- consume_vc  in  NUM_PORTS*VC_W  VC charged for each sent flit
- credit_count  out  NUM_PORTS*NUM_VCS*CNT_W  per port/VC count; CNT_W = $clog2(BUF_DEPTH+1); index p*NUM_VCS+v
- credit_avail  out  NUM_PORTS*NUM_VCS  count != 0
- cq_overflow  out  1  sticky: credit dropped because its queue was full
- cr_overflow  out  1  sticky: credit released into a count already at BUF_DEPTH
- cr_underflow  out  1  sticky: consume on a zero count
- idle  out  1  all credit queues empty

## Operation
- **Cycle counter.** Free-running TS_W-bit `now`, wraps modulo 2^TS_W.
- **Delay register.**
  - Loaded from cfg_delay when cfg_we is high and idle is high.
  - cfg_we while not idle is ignored.
  - Because the delay cannot change while credits are queued, queue timestamps are non-decreasing in FIFO order.
- **Enqueue.**
  - cr_in_valid[p] pushes {vc, ts = now + delay} onto queue p.
  - A delay of 0 is treated as 1.
- **Release.**
  - Head of queue p pops when valid and ((now − ts) mod 2^TS_W) < 2^(TS_W−1); this is a wrap-safe `now ≥ ts`.
  - An entry never pops in the cycle it is pushed.
  - At most one pop per port per cycle; there is no head bypass.
- **Counter update.** Per port/VC, per cycle: next = cnt + rel − use.
  - rel: a pop on that VC; use: consume_valid on that VC.
  - rel and use in the same cycle: count unchanged, no flags.
  - rel only, cnt == BUF_DEPTH: hold, set cr_overflow.
  - use only, cnt == 0: hold, set cr_underflow.
- **Queue full.** Push to a full queue with no same-cycle pop: credit dropped, cq_overflow set. Push and pop together on a full queue: push accepted.
- **Wrap-around.** Queue pointers are log2(CQ_DEPTH)+1 bits, so full and empty are distinguished by the MSB.
- **Sticky flags.** Cleared only by reset.

## Timing
- **Reset values:**
  - all counts = BUF_DEPTH; credit_avail all ones;
  - queues empty; idle = 1;
  - now = 0; delay = 1;
  - all flags 0.
- **Return latency.** A credit sampled at the edge ending cycle t is visible on credit_count in cycle t+1+max(delay,1), provided its queue head is not blocked.
- **Consume latency.** Consume sampled at the edge ending cycle t is visible in cycle t+1.
- **Outputs.** All outputs are registered or derived from registers only; there is no combinational input-to-output path.
- **Reset mid-operation.** Queued credits are discarded and counts restored to BUF_DEPTH in the same step.

## Structure
- Shared package noc_pkg holds:
  - the VC_W and CNT_W derivation functions;
  - the credit-queue entry struct {vc, ts};
  - the default parameter constants.
- One sub-module, credit_queue (a single-port timestamped FIFO with push, pop-when-due and full/empty), is instantiated NUM_PORTS times.
- Counters, the cycle counter, the delay register and the flags live in credit_tracker.

## Test plan
- **Reset:** after reset with defaults → every credit_count = 4, idle = 1, all flags 0.
- **Delay:** cfg_delay = 3 while idle; credit on port 1 VC 2 in cycle 10 after a consume → count at 3 through cycle 13, returns to 4 in cycle 14.
- **Simultaneous events:** consume and release on the same port/VC in the same cycle → count unchanged, no flags.
- **Queue full:** 9 credits on port 0 in consecutive cycles, delay = 20, CQ_DEPTH = 8 → 9th dropped, cq_overflow = 1, eight releases follow.
- **Under/overflow:** 5 consumes on VC 0 from count 4 → count 0, cr_underflow = 1. A release into a full count → cr_overflow = 1, count stays 4.
- **Timestamp wrap and mid-run reset:**
  - Run to now = 0xFFFE, return a credit with delay 4 → released on the wrapped cycle, count correct.
  - rst_n low mid-queue → queues empty, counts = 4 immediately.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router defaults, width helpers and credit-queue entry type
package noc_pkg;

  localparam int DEF_NUM_PORTS = 5;
  localparam int DEF_NUM_VCS   = 4;
  localparam int DEF_BUF_DEPTH = 4;
  localparam int DEF_CQ_DEPTH  = 8;
  localparam int DEF_DELAY_W   = 12;
  localparam int DEF_TS_W      = 16;

  // Entry fields are sized for the widest supported configuration
  // (VC_W < CQ_VC_MAX_W, TS_W < CQ_TS_MAX_W); users keep the low bits.
  localparam int CQ_VC_MAX_W = 8;
  localparam int CQ_TS_MAX_W = 32;

  // VC index width; a single VC still needs one bit.
  function automatic int vc_width(input int num_vcs);
    return (num_vcs > 1) ? $clog2(num_vcs) : 1;
  endfunction

  // Credit counter width, able to hold 0..buf_depth inclusive.
  function automatic int cnt_width(input int buf_depth);
    return $clog2(buf_depth + 1);
  endfunction

  typedef struct packed {
    logic [CQ_VC_MAX_W-1:0] vc;
    logic [CQ_TS_MAX_W-1:0] ts;
  } cq_entry_t;

endpackage

// File: rtl/credit_tracker_if.sv
// rtl/credit_tracker_if.sv - per-port credit return and flit consume signals
interface credit_tracker_if
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int VC_W      = 2
);

  logic [NUM_PORTS-1:0]      cr_in_valid;
  logic [NUM_PORTS*VC_W-1:0] cr_in_vc;
  logic [NUM_PORTS-1:0]      consume_valid;
  logic [NUM_PORTS*VC_W-1:0] consume_vc;

  modport master (
    output cr_in_valid,
    output cr_in_vc,
    output consume_valid,
    output consume_vc
  );

  modport slave (
    input cr_in_valid,
    input cr_in_vc,
    input consume_valid,
    input consume_vc
  );

endinterface

// File: rtl/credit_queue.sv
// rtl/credit_queue.sv - single-port timestamped credit FIFO that pops its head when due
module credit_queue
  import noc_pkg::*;
#(
  parameter int CQ_DEPTH = DEF_CQ_DEPTH,
  parameter int VC_W     = 2,
  parameter int TS_W     = DEF_TS_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TS_W-1:0] now,
  input  logic            push,
  input  logic [VC_W-1:0] push_vc,
  input  logic [TS_W-1:0] push_ts,
  output logic            pop,
  output logic [VC_W-1:0] pop_vc,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = $clog2(CQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  cq_entry_t        mem [CQ_DEPTH];
  cq_entry_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TS_W-1:0]  head_age;
  logic             accept;
  logic             unused_head_bits;

  // Extra pointer MSB tells a full queue (MSBs differ) from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // Head is due once now has reached ts in wrap-safe terms: the modular
  // age lies in the lower half of the timestamp range.
  assign head     = mem[rd_ptr[IDX_W-1:0]];
  assign head_age = now - head.ts[TS_W-1:0];
  assign pop      = !empty && !head_age[TS_W-1];
  assign pop_vc   = head.vc[VC_W-1:0];

  // A full queue still takes a push when its head leaves in the same cycle.
  assign accept = push && (!full || pop);

  assign unused_head_bits = ^{head.vc[CQ_VC_MAX_W-1:VC_W], head.ts[CQ_TS_MAX_W-1:TS_W]};

  // Entry storage; contents past the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[IDX_W-1:0]] <= '{vc: CQ_VC_MAX_W'(push_vc), ts: CQ_TS_MAX_W'(push_ts)};
    end
  end

  // Advance write pointer on accepted pushes and read pointer on pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/credit_tracker.sv
// rtl/credit_tracker.sv - per-port/VC downstream credit counters with delayed credit return
module credit_tracker
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int NUM_VCS   = DEF_NUM_VCS,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CQ_DEPTH  = DEF_CQ_DEPTH,
  parameter int DELAY_W   = DEF_DELAY_W,
  parameter int TS_W      = DEF_TS_W,
  localparam int VC_W     = vc_width(NUM_VCS),
  localparam int CNT_W    = cnt_width(BUF_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic [DELAY_W-1:0]                 cfg_delay,
  credit_tracker_if.slave                    cr_if,
  output logic [NUM_PORTS*NUM_VCS*CNT_W-1:0] credit_count,
  output logic [NUM_PORTS*NUM_VCS-1:0]       credit_avail,
  output logic                               cq_overflow,
  output logic                               cr_overflow,
  output logic                               cr_underflow,
  output logic                               idle
);

  localparam int              NUM_CNT = NUM_PORTS * NUM_VCS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

  logic [TS_W-1:0]           now;
  logic [DELAY_W-1:0]        delay_q;
  logic [DELAY_W-1:0]        eff_delay;
  logic [TS_W-1:0]           push_ts;
  logic [NUM_PORTS-1:0]      q_pop;
  logic [NUM_PORTS-1:0]      q_full;
  logic [NUM_PORTS-1:0]      q_empty;
  logic [NUM_PORTS*VC_W-1:0] q_pop_vc;
  logic [NUM_CNT-1:0]        release_hit;
  logic [NUM_CNT-1:0]        consume_hit;
  logic [CNT_W-1:0]          cnt_q [NUM_CNT];
  logic [CNT_W-1:0]          cnt_d [NUM_CNT];
  logic                      ovf_hit;
  logic                      unf_hit;
  logic                      cq_hit;

  // A zero delay would let a credit be due in its own push cycle; use 1.
  assign eff_delay = (delay_q == '0) ? DELAY_W'(1) : delay_q;
  assign push_ts   = now + TS_W'(eff_delay);
  assign idle      = &q_empty;

  // Free-running timestamp counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now <= '0;
    end else begin
      now <= now + TS_W'(1);
    end
  end

  // Delay only changes with all queues empty, keeping queued timestamps ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= DELAY_W'(1);
    end else if (cfg_we && idle) begin
      delay_q <= cfg_delay;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cq
    credit_queue #(
      .CQ_DEPTH (CQ_DEPTH),
      .VC_W     (VC_W),
      .TS_W     (TS_W)
    ) u_cq (
      .clk     (clk),
      .rst_n   (rst_n),
      .now     (now),
      .push    (cr_if.cr_in_valid[p]),
      .push_vc (cr_if.cr_in_vc[p*VC_W +: VC_W]),
      .push_ts (push_ts),
      .pop     (q_pop[p]),
      .pop_vc  (q_pop_vc[p*VC_W +: VC_W]),
      .full    (q_full[p]),
      .empty   (q_empty[p])
    );

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      assign release_hit[p*NUM_VCS+v] = q_pop[p] &&
                                        (q_pop_vc[p*VC_W +: VC_W] == VC_W'(v));
      assign consume_hit[p*NUM_VCS+v] = cr_if.consume_valid[p] &&
                                        (cr_if.consume_vc[p*VC_W +: VC_W] == VC_W'(v));
    end
  end

  // A credit is lost only when its queue is full and nothing leaves this cycle.
  assign cq_hit = |(cr_if.cr_in_valid & q_full & ~q_pop);

  // Net each counter's release against its consume and catch range errors.
  always_comb begin
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (release_hit[i] && !consume_hit[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_hit = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (consume_hit[i] && !release_hit[i]) begin
        if (cnt_q[i] == '0) begin
          unf_hit = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Credit counters start full: the downstream buffers are empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= CNT_MAX;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Error flags stay set until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_overflow  <= 1'b0;
      cr_overflow  <= 1'b0;
      cr_underflow <= 1'b0;
    end else begin
      if (cq_hit) begin
        cq_overflow <= 1'b1;
      end
      if (ovf_hit) begin
        cr_overflow <= 1'b1;
      end
      if (unf_hit) begin
        cr_underflow <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_out
    assign credit_count[i*CNT_W +: CNT_W] = cnt_q[i];
    assign credit_avail[i]                = (cnt_q[i] != '0);
  end

endmodule

// File: tb/tb_credit_tracker.sv
// tb/tb_credit_tracker.sv - directed self-checking bench for credit_tracker
module tb_credit_tracker;
  import noc_pkg::*;

  localparam int NP    = 5;
  localparam int NV    = 4;
  localparam int VC_W  = 2;
  localparam int CNT_W = 3;
  localparam logic [NP*NV*CNT_W-1:0] ALL_FULL = {20{3'd4}};

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cfg_we = 1'b0;
  logic [11:0]             cfg_delay = '0;
  logic [NP*NV*CNT_W-1:0]  credit_count;
  logic [NP*NV-1:0]        credit_avail;
  logic                    cq_overflow;
  logic                    cr_overflow;
  logic                    cr_underflow;
  logic                    idle;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  credit_tracker_if #(.NUM_PORTS(NP), .VC_W(VC_W)) cif ();

  credit_tracker #(
    .NUM_PORTS (NP),
    .NUM_VCS   (NV),
    .BUF_DEPTH (4),
    .CQ_DEPTH  (8),
    .DELAY_W   (12),
    .TS_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_delay    (cfg_delay),
    .cr_if        (cif),
    .credit_count (credit_count),
    .credit_avail (credit_avail),
    .cq_overflow  (cq_overflow),
    .cr_overflow  (cr_overflow),
    .cr_underflow (cr_underflow),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int p, input int v);
    return credit_count[(p*NV+v)*CNT_W +: CNT_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    edge_cnt++;
  endtask

  task automatic clear_inputs();
    cif.cr_in_valid   = '0;
    cif.cr_in_vc      = '0;
    cif.consume_valid = '0;
    cif.consume_vc    = '0;
    cfg_we            = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic set_delay(input int d);
    cfg_we    = 1'b1;
    cfg_delay = 12'(d);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic send_credit(input int p, input int v);
    cif.cr_in_valid[p]               = 1'b1;
    cif.cr_in_vc[p*VC_W +: VC_W]     = VC_W'(v);
    tick();
    cif.cr_in_valid                  = '0;
  endtask

  task automatic send_consume(input int p, input int v);
    cif.consume_valid[p]             = 1'b1;
    cif.consume_vc[p*VC_W +: VC_W]   = VC_W'(v);
    tick();
    cif.consume_valid                = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    do_reset();

    // Reset state
    check_eq("rst_counts", credit_count, ALL_FULL);
    check_eq("rst_avail", credit_avail, 20'hFFFFF);
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_flags", {cq_overflow, cr_overflow, cr_underflow}, 3'b000);

    // Delay 3: consume then return on port 1 VC 2
    set_delay(3);
    send_consume(1, 2);
    check_eq("consume_lat", cnt_of(1, 2), 3'd3);
    check_eq("other_vc", cnt_of(1, 1), 3'd4);
    send_credit(1, 2);
    check_eq("dly_busy", idle, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      check_eq($sformatf("dly_hold_%0d", k), cnt_of(1, 2), 3'd3);
      tick();
    end
    check_eq("dly_ret", cnt_of(1, 2), 3'd4);
    check_eq("dly_idle", idle, 1'b1);

    // Release and consume on the same port/VC in the same cycle
    send_consume(2, 1);
    send_credit(2, 1);
    tick();
    tick();
    check_eq("sim_pre", cnt_of(2, 1), 3'd3);
    send_consume(2, 1);
    check_eq("sim_cnt", cnt_of(2, 1), 3'd3);
    check_eq("sim_flags", {cr_overflow, cr_underflow}, 2'b00);
    check_eq("sim_idle", idle, 1'b1);

    // Queue full on port 0 with delay 20
    set_delay(20);
    for (int i = 0; i < 8; i++) send_consume(0, i % 4);
    check_eq("qf_pre0", cnt_of(0, 0), 3'd2);
    check_eq("qf_pre3", cnt_of(0, 3), 3'd2);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check_eq("qf_not_yet", cq_overflow, 1'b0);
      send_credit(0, i % 4);
    end
    check_eq("qf_drop", cq_overflow, 1'b1);
    check_eq("qf_busy", idle, 1'b0);
    repeat (11) tick();
    check_eq("qf_before_rel", cnt_of(0, 0), 3'd2);
    tick();
    check_eq("qf_first_rel", cnt_of(0, 0), 3'd3);
    repeat (7) tick();
    check_eq("qf_all_rel", credit_count[4*CNT_W-1:0], {4{3'd4}});
    check_eq("qf_idle", idle, 1'b1);
    check_eq("qf_no_ovf", cr_overflow, 1'b0);

    // Underflow and overflow
    do_reset();
    for (int i = 0; i < 4; i++) send_consume(0, 0);
    check_eq("unf_zero", cnt_of(0, 0), 3'd0);
    check_eq("unf_avail", credit_avail[0], 1'b0);
    check_eq("unf_pre", cr_underflow, 1'b0);
    send_consume(0, 0);
    check_eq("unf_hold", cnt_of(0, 0), 3'd0);
    check_eq("unf_flag", cr_underflow, 1'b1);
    send_credit(3, 1);
    check_eq("ovf_pre", cr_overflow, 1'b0);
    tick();
    check_eq("ovf_flag", cr_overflow, 1'b1);
    check_eq("ovf_hold", cnt_of(3, 1), 3'd4);

    // Timestamp wrap with delay 4
    do_reset();
    set_delay(4);
    send_consume(4, 3);
    while (edge_cnt != 32'hFFFE) tick();
    check_eq("wrap_pre", cnt_of(4, 3), 3'd3);
    send_credit(4, 3);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("wrap_hold_%0d", k), cnt_of(4, 3), 3'd3);
      tick();
    end
    check_eq("wrap_ret", cnt_of(4, 3), 3'd4);
    check_eq("wrap_idle", idle, 1'b1);

    // Asynchronous reset with credits queued
    send_consume(0, 0);
    send_credit(0, 0);
    send_credit(1, 1);
    check_eq("mid_busy", idle, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_counts", credit_count, ALL_FULL);
    check_eq("mid_idle", idle, 1'b1);
    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    repeat (8) tick();
    check_eq("post_counts", credit_count, ALL_FULL);
    check_eq("post_flags", {cq_overflow, cr_overflow, cr_underflow}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
